// File: rtl/flash_line_cache.sv
// flash_line_cache
//   Read-only, direct-mapped line cache in front of the QSPI XIP flash
//   controller. Serves CPU reads as an AHB-Lite slave with zero wait states
//   on a hit; on a miss it refills one 16-byte line (words 0..3 in order)
//   through an AHB-Lite master port, then answers the pending read.
//
// Ports
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   HSEL, HREADY, HTRANS,  AHB-Lite slave address/control from the CPU
//   HSIZE, HWRITE, HADDR
//   HREADYOUT, HRDATA      slave ready / read data
//   M_HSEL, M_HADDR,       AHB-Lite master port to the QSPI controller
//   M_HTRANS, M_HSIZE,     (word reads only, IDLE or NONSEQ)
//   M_HWRITE
//   M_HREADY, M_HRDATA     downstream ready / read data
//   INV                    single-cycle pulse, invalidates every line
//   HITS, MISSES           wrapping 32-bit event counters
//   dbg_state              current FSM state (IDLE/FILL/RESP)
//
// Handshake: a CPU address phase is taken when HSEL & HREADY & HTRANS[1]
// while this block drives HREADYOUT=1; the data phase ends on the first
// cycle with HREADYOUT=1. Downstream, an address phase (M_HTRANS=NONSEQ)
// and a data phase both complete on a cycle with M_HREADY=1; while
// M_HREADY=0 the address and transfer type are held unchanged.
module flash_line_cache #(
    parameter int NLINES = 8,
    parameter int AW     = 24
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HADDR,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        M_HSEL,
    output logic [31:0] M_HADDR,
    output logic [1:0]  M_HTRANS,
    output logic [2:0]  M_HSIZE,
    output logic        M_HWRITE,
    input  logic        M_HREADY,
    input  logic [31:0] M_HRDATA,
    input  logic        INV,
    output logic [31:0] HITS,
    output logic [31:0] MISSES,
    output logic [1:0]  dbg_state
);

    localparam int IW = $clog2(NLINES);
    localparam int TW = AW - 4 - IW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state, state_n;

    // Registered CPU request (word address only; byte offset is ignored).
    logic              pending;
    logic              wr_q;
    logic [AW-1:2]     addr_q;

    // Line storage.
    logic [NLINES-1:0] line_valid;
    logic [TW-1:0]     line_tag  [NLINES];
    logic [31:0]       line_data [NLINES][4];

    // Refill sequencing.
    logic [2:0]        addr_cnt;
    logic [2:0]        data_cnt;
    logic              dphase;

    // Decoded request fields and combinational events.
    logic [IW-1:0]     idx;
    logic [TW-1:0]     tag_q;
    logic [1:0]        wsel;
    logic [31:0]       line_word;
    logic              hit;
    logic              hit_ev;
    logic              miss_ev;
    logic              m_issue;
    logic              capture;
    logic              fill_done;
    logic              accept;

    logic              unused_inputs;
    assign unused_inputs = ^{HSIZE, HTRANS[0], HADDR[31:AW], HADDR[1:0]};

    assign idx       = addr_q[3+IW:4];
    assign tag_q     = addr_q[AW-1:4+IW];
    assign wsel      = addr_q[3:2];
    assign line_word = line_data[idx][wsel];
    assign hit       = line_valid[idx] && (line_tag[idx] == tag_q);

    // Only sample a new address phase while this slave is not stalling the
    // bus, so the request under refill can never be overwritten.
    assign accept    = HSEL && HREADY && HTRANS[1] && HREADYOUT;

    assign capture   = (state == ST_FILL) && dphase && M_HREADY;
    assign fill_done = capture && (data_cnt == 3'd3);

    assign dbg_state = state;
    assign M_HSIZE   = 3'b010;
    assign M_HWRITE  = 1'b0;

    always_comb begin
        state_n   = state;
        HREADYOUT = 1'b1;
        HRDATA    = 32'h0;
        hit_ev    = 1'b0;
        miss_ev   = 1'b0;
        m_issue   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pending && !wr_q) begin
                    if (hit) begin
                        HRDATA = line_word;
                        hit_ev = 1'b1;
                    end else begin
                        HREADYOUT = 1'b0;
                        miss_ev   = 1'b1;
                        state_n   = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                HREADYOUT = 1'b0;
                m_issue   = !addr_cnt[2];
                if (fill_done) state_n = ST_RESP;
            end
            ST_RESP: begin
                HRDATA  = line_word;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Downstream address phase: line base of the request plus addr_cnt.
    always_comb begin
        M_HSEL   = m_issue;
        M_HTRANS = m_issue ? 2'b10 : 2'b00;
        M_HADDR  = 32'h0;
        if (m_issue) begin
            M_HADDR[AW-1:4] = addr_q[AW-1:4];
            M_HADDR[3:2]    = addr_cnt[1:0];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= ST_IDLE;
            pending    <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            addr_cnt   <= 3'd0;
            data_cnt   <= 3'd0;
            dphase     <= 1'b0;
            line_valid <= '0;
            HITS       <= 32'h0;
            MISSES     <= 32'h0;
        end else begin
            state <= state_n;

            if (HREADY && HREADYOUT) begin
                pending <= accept;
                if (accept) begin
                    addr_q <= HADDR[AW-1:2];
                    wr_q   <= HWRITE;
                end
            end

            if (hit_ev)  HITS   <= HITS + 32'd1;
            if (miss_ev) MISSES <= MISSES + 32'd1;

            if (miss_ev) begin
                addr_cnt <= 3'd0;
                data_cnt <= 3'd0;
                dphase   <= 1'b0;
            end else if (state == ST_FILL && M_HREADY) begin
                if (m_issue) addr_cnt <= addr_cnt + 3'd1;
                if (dphase)  data_cnt <= data_cnt + 3'd1;
                dphase <= m_issue;
            end

            // Later assignments win: a line completing its refill stays
            // valid even when INV lands in the same cycle.
            if (INV)       line_valid      <= '0;
            if (miss_ev)   line_valid[idx] <= 1'b0;
            if (fill_done) line_valid[idx] <= 1'b1;
        end
    end

    // Line payload needs no reset; the valid bits guard it.
    always_ff @(posedge HCLK) begin
        if (capture)   line_data[idx][data_cnt[1:0]] <= M_HRDATA;
        if (fill_done) line_tag[idx] <= tag_q;
    end

endmodule
